// File: rtl/vga_pkg.sv
// Shared constants and types for the tile text writer.
// Holds the screen geometry, address/data widths, control codes and FSM state encoding.
package vga_pkg;

  localparam int H_TILES        = 80;
  localparam int V_TILES        = 30;
  localparam int ADDR_COL_WIDTH = 7;
  localparam int ADDR_ROW_WIDTH = 5;
  localparam int DATA_WIDTH     = 7;

  localparam logic [6:0] ASCII_BS = 7'h08;
  localparam logic [6:0] ASCII_LF = 7'h0A;
  localparam logic [6:0] ASCII_FF = 7'h0C;
  localparam logic [6:0] ASCII_CR = 7'h0D;

  localparam logic [6:0] PRINT_FIRST = 7'h20;
  localparam logic [6:0] PRINT_LAST  = 7'h7E;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t CLEAR = 1'b1;

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row counter with wrap at the screen edges (no scrolling).
// Control priority: home > newline > cr > dec > inc.
module text_cursor #(
  parameter int H_TILES   = vga_pkg::H_TILES,
  parameter int V_TILES   = vga_pkg::V_TILES,
  parameter int COL_WIDTH = vga_pkg::ADDR_COL_WIDTH,
  parameter int ROW_WIDTH = vga_pkg::ADDR_ROW_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 newline,
  input  logic                 cr,
  input  logic                 dec,
  input  logic                 home,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] row
);

  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(H_TILES - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(V_TILES - 1);

  logic [ROW_WIDTH-1:0] row_next;

  assign row_next = (row == ROW_LAST) ? '0 : row + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else if (newline) begin
      col <= '0;
      row <= row_next;
    end else if (cr) begin
      col <= '0;
    end else if (dec) begin
      if (col != '0) col <= col - 1'b1;
    end else if (inc) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row_next;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_writer.sv
// Character-stream to tile-buffer writer with CR/LF/BS handling.
// Optional screen clear on FF is built when TEXT_WRITER_CLEAR_EN is defined.
module text_writer #(
  parameter int H_TILES        = vga_pkg::H_TILES,
  parameter int V_TILES        = vga_pkg::V_TILES,
  parameter int ADDR_COL_WIDTH = vga_pkg::ADDR_COL_WIDTH,
  parameter int ADDR_ROW_WIDTH = vga_pkg::ADDR_ROW_WIDTH,
  parameter int DATA_WIDTH     = vga_pkg::DATA_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      char_valid_i,
  input  logic [DATA_WIDTH-1:0]     char_i,
  output logic                      char_ready_o,
  output logic                      wr_en_o,
  output logic [ADDR_COL_WIDTH-1:0] col_w_o,
  output logic [ADDR_ROW_WIDTH-1:0] row_w_o,
  output logic [DATA_WIDTH-1:0]     din_o,
  output logic [ADDR_COL_WIDTH-1:0] cursor_col_o,
  output logic [ADDR_ROW_WIDTH-1:0] cursor_row_o,
  output logic                      busy_o
);

  import vga_pkg::*;

  state_t state;
  logic   accept;
  logic   is_print, is_cr, is_lf, is_bs;
  logic   do_inc, do_nl, do_cr, do_dec, do_home;

  assign char_ready_o = (state == IDLE);
  assign accept       = char_valid_i && char_ready_o;

  assign is_print = (char_i >= DATA_WIDTH'(PRINT_FIRST)) && (char_i <= DATA_WIDTH'(PRINT_LAST));
  assign is_cr    = (char_i == DATA_WIDTH'(ASCII_CR));
  assign is_lf    = (char_i == DATA_WIDTH'(ASCII_LF));
  assign is_bs    = (char_i == DATA_WIDTH'(ASCII_BS));

  assign do_inc = accept && is_print;
  assign do_nl  = accept && is_lf;
  assign do_cr  = accept && is_cr;
  // Backspace at column 0 is swallowed: no cursor move and no write.
  assign do_dec = accept && is_bs && (cursor_col_o != '0);

`ifdef TEXT_WRITER_CLEAR_EN
  localparam logic [ADDR_COL_WIDTH-1:0] COL_LAST = ADDR_COL_WIDTH'(H_TILES - 1);
  localparam logic [ADDR_ROW_WIDTH-1:0] ROW_LAST = ADDR_ROW_WIDTH'(V_TILES - 1);

  logic [ADDR_COL_WIDTH-1:0] clr_col;
  logic [ADDR_ROW_WIDTH-1:0] clr_row;
  logic                      clr_last;
  logic                      is_ff;

  assign is_ff    = (char_i == DATA_WIDTH'(ASCII_FF));
  assign clr_last = (clr_col == COL_LAST) && (clr_row == ROW_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      clr_col <= '0;
      clr_row <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_ff) begin
            state   <= CLEAR;
            clr_col <= '0;
            clr_row <= '0;
          end
        end
        default: begin
          if (clr_last) begin
            state   <= IDLE;
            clr_col <= '0;
            clr_row <= '0;
          end else if (clr_col == COL_LAST) begin
            clr_col <= '0;
            clr_row <= clr_row + 1'b1;
          end else begin
            clr_col <= clr_col + 1'b1;
          end
        end
      endcase
    end
  end

  assign do_home = (state == CLEAR) && clr_last;
  assign busy_o  = (state == CLEAR);
`else
  assign state   = IDLE;
  assign do_home = 1'b0;
  assign busy_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_en_o <= 1'b0;
      col_w_o <= '0;
      row_w_o <= '0;
      din_o   <= '0;
    end else begin
      wr_en_o <= 1'b0;
      if (do_inc) begin
        wr_en_o <= 1'b1;
        col_w_o <= cursor_col_o;
        row_w_o <= cursor_row_o;
        din_o   <= char_i;
      end else if (do_dec) begin
        wr_en_o <= 1'b1;
        col_w_o <= cursor_col_o - 1'b1;
        row_w_o <= cursor_row_o;
        din_o   <= '0;
      end
`ifdef TEXT_WRITER_CLEAR_EN
      if (state == CLEAR) begin
        wr_en_o <= 1'b1;
        col_w_o <= clr_col;
        row_w_o <= clr_row;
        din_o   <= '0;
      end
`endif
    end
  end

  text_cursor #(
    .H_TILES   (H_TILES),
    .V_TILES   (V_TILES),
    .COL_WIDTH (ADDR_COL_WIDTH),
    .ROW_WIDTH (ADDR_ROW_WIDTH)
  ) u_cursor (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .inc     (do_inc),
    .newline (do_nl),
    .cr      (do_cr),
    .dec     (do_dec),
    .home    (do_home),
    .col     (cursor_col_o),
    .row     (cursor_row_o)
  );

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer (25 MHz clock).
// Clear-sweep checks are built when TEXT_WRITER_CLEAR_EN is defined.
module tb_text_writer;

  logic       clk;
  logic       rstn;
  logic       char_valid;
  logic [6:0] char_in;
  logic       char_ready;
  logic       wr_en;
  logic [6:0] col_w;
  logic [4:0] row_w;
  logic [6:0] din;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  text_writer #(
    .H_TILES        (80),
    .V_TILES        (30),
    .ADDR_COL_WIDTH (7),
    .ADDR_ROW_WIDTH (5),
    .DATA_WIDTH     (7)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .char_valid_i (char_valid),
    .char_i       (char_in),
    .char_ready_o (char_ready),
    .wr_en_o      (wr_en),
    .col_w_o      (col_w),
    .row_w_o      (row_w),
    .din_o        (din),
    .cursor_col_o (cursor_col),
    .cursor_row_o (cursor_row),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [6:0] c);
    @(negedge clk);
    char_valid = 1'b1;
    char_in    = c;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic send_n(input logic [6:0] c, input int n);
    for (int k = 0; k < n; k++) send(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int busy_cnt, wr_cnt, bad;
    int ec, er;
    bit done;

    rstn       = 1'b0;
    char_valid = 1'b0;
    char_in    = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", {col_w, row_w}, 0);
    check("rst_din", din, 0);
    check("rst_cursor", {cursor_col, cursor_row}, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", char_ready, 1);
    rstn = 1'b1;

    // single printable character
    send(7'h41);
    check("A_wr_en", wr_en, 1);
    check("A_col_w", col_w, 0);
    check("A_row_w", row_w, 0);
    check("A_din", din, 7'h41);
    check("A_cursor", {cursor_col, cursor_row}, {7'd1, 5'd0});
    @(negedge clk);
    check("A_pulse_end", wr_en, 0);

    // 80 back-to-back characters from (0,0)
    do_reset();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b_wr_en", wr_en, 1);
        check("b2b_col_w", col_w, i - 1);
      end
      char_valid = 1'b1;
      char_in    = 7'(7'h30 + (i % 10));
    end
    @(negedge clk);
    char_valid = 1'b0;
    check("b2b_last_wr_en", wr_en, 1);
    check("b2b_last_col", col_w, 79);
    check("b2b_last_row", row_w, 0);
    check("b2b_last_din", din, 7'h39);
    check("b2b_cursor", {cursor_col, cursor_row}, {7'd0, 5'd1});

    // move to (5,29), then LF wraps to (0,0), BS at column 0 is a no-op
    send_n(7'h0A, 28);
    send_n(7'h2E, 5);
    check("pos_5_29", {cursor_col, cursor_row}, {7'd5, 5'd29});
    send(7'h0A);
    check("lf_no_write", wr_en, 0);
    check("lf_wrap", {cursor_col, cursor_row}, 0);
    send(7'h08);
    check("bs0_no_write", wr_en, 0);
    check("bs0_cursor", {cursor_col, cursor_row}, 0);

    // BS from (3,2)
    send_n(7'h0A, 2);
    send_n(7'h7E, 3);
    check("pos_3_2", {cursor_col, cursor_row}, {7'd3, 5'd2});
    send(7'h08);
    check("bs_wr_en", wr_en, 1);
    check("bs_addr", {col_w, row_w}, {7'd2, 5'd2});
    check("bs_din", din, 0);
    check("bs_cursor", {cursor_col, cursor_row}, {7'd2, 5'd2});

    // ignored codes and CR
    send(7'h7F);
    check("del_no_write", wr_en, 0);
    check("del_cursor", {cursor_col, cursor_row}, {7'd2, 5'd2});
    send(7'h05);
    check("ctl_no_write", wr_en, 0);
    check("ctl_cursor", {cursor_col, cursor_row}, {7'd2, 5'd2});
    send(7'h1F);
    check("us_cursor", {cursor_col, cursor_row}, {7'd2, 5'd2});
    send(7'h0D);
    check("cr_no_write", wr_en, 0);
    check("cr_cursor", {cursor_col, cursor_row}, {7'd0, 5'd2});

    // printable wrap at the bottom-right corner returns to (0,0)
    send_n(7'h0A, 27);
    check("pos_0_29", {cursor_col, cursor_row}, {7'd0, 5'd29});
    send_n(7'h20, 79);
    check("pos_79_29", {cursor_col, cursor_row}, {7'd79, 5'd29});
    send(7'h5F);
    check("corner_addr", {col_w, row_w}, {7'd79, 5'd29});
    check("corner_wrap", {cursor_col, cursor_row}, 0);

    // async reset while a write pulse is on the outputs
    send(7'h42);
    check("pre_rst_wr", wr_en, 1);
    #5 rstn = 1'b0;
    #1;
    check("async_wr_en", wr_en, 0);
    check("async_din", din, 0);
    check("async_cursor", {cursor_col, cursor_row}, 0);
    @(negedge clk);
    rstn = 1'b1;

    send(7'h51);
    check("pre_ff_cursor", {cursor_col, cursor_row}, {7'd1, 5'd0});
`ifdef TEXT_WRITER_CLEAR_EN
    @(negedge clk);
    char_valid = 1'b1;
    char_in    = 7'h0C;
    @(negedge clk);
    char_in = 7'h5A;  // held valid during the sweep; must be ignored
    check("ff_busy", busy, 1);
    check("ff_ready", char_ready, 0);
    busy_cnt = 0;
    wr_cnt   = 0;
    bad      = 0;
    ec       = 0;
    er       = 0;
    done     = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (wr_en) begin
        if (col_w !== 7'(ec) || row_w !== 5'(er) || din !== 7'h00) bad++;
        wr_cnt++;
        if (ec == 79) begin
          ec = 0;
          er++;
        end else begin
          ec++;
        end
      end
      if (busy) begin
        busy_cnt++;
        if (char_ready) bad++;
      end else begin
        done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    char_valid = 1'b0;
    check("clr_done", done, 1);
    check("clr_busy_cycles", busy_cnt, 2400);
    check("clr_writes", wr_cnt, 2400);
    check("clr_bad_writes", bad, 0);
    check("clr_cursor", {cursor_col, cursor_row}, 0);
    check("clr_ready", char_ready, 1);
    @(negedge clk);
    check("clr_valid_ignored", {cursor_col, cursor_row}, 0);

    // reset 100 cycles into a clear
    send(7'h0C);
    repeat (100) @(negedge clk);
    check("mid_clr_busy", busy, 1);
    #5 rstn = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_addr", {col_w, row_w, din}, 0);
    check("abort_cursor", {cursor_col, cursor_row}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("abort_ready", char_ready, 1);
    check("abort_no_write", wr_en, 0);
`else
    send(7'h0C);
    check("ff_no_write", wr_en, 0);
    check("ff_no_busy", busy, 0);
    check("ff_ready", char_ready, 1);
    check("ff_cursor", {cursor_col, cursor_row}, {7'd1, 5'd0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SHALL have parameter H_TILES, default 80, meaning tiles per row.
REQ-002 SHALL have parameter V_TILES, default 30, meaning tile rows.
REQ-003 SHALL have parameters ADDR_COL_WIDTH (7) and ADDR_ROW_WIDTH (5), meaning column and row address widths; DATA_WIDTH (7), meaning character code width.
REQ-004 SHALL have port clk_i, input, 1 bit: the single 25 MHz clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rstn_i, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port char_valid_i, input, 1 bit: an upstream character is offered.
REQ-007 SHALL have port char_i, input, DATA_WIDTH bits: the offered ASCII code.
REQ-008 SHALL have port char_ready_o, output, 1 bit: the character is accepted when valid and ready are both high at a rising edge.
REQ-009 SHALL have ports wr_en_o (1), col_w_o (ADDR_COL_WIDTH), row_w_o (ADDR_ROW_WIDTH) and din_o (DATA_WIDTH), all outputs: the write port to the downstream tile screen buffer.
REQ-010 SHALL have ports cursor_col_o and cursor_row_o, outputs: the current cursor position.
REQ-011 SHALL have port busy_o, output, 1 bit: a screen clear is in progress.

Function
REQ-012 SHALL implement states IDLE and CLEAR; char_ready_o SHALL be high exactly when in IDLE (combinational from state).
REQ-013 SHALL register all write-port outputs; wr_en_o SHALL be a one-cycle pulse in the cycle after acceptance, sustaining one character per cycle.
REQ-014 For printable codes 0x20-0x7E, SHALL write char_i at the pre-accept cursor and advance the column; column 79 SHALL wrap to 0 with row+1.
REQ-015 Row increment from row 29 SHALL wrap to row 0 (no scrolling).
REQ-016 For 0x0D (CR), SHALL set column 0 with no write.
REQ-017 For 0x0A (LF), SHALL set column 0 and row+1 (wrapping) with no write.
REQ-018 For 0x08 (BS) with column > 0, SHALL decrement the column and write 0x00 at the new position; at column 0 it SHALL be consumed with no effect.
REQ-019 All other codes, including 0x00-0x1F not listed and 0x7F, SHALL be consumed with no write and no cursor change.
REQ-020 For 0x0C (FF), with the feature enabled, SHALL enter CLEAR and issue 2400 consecutive writes of 0x00 in row-major order, from (0,0) to (79,29), one per cycle.
REQ-021 On the cycle of the last clear write, the FSM SHALL return to IDLE with the cursor at (0,0); busy_o SHALL equal (state == CLEAR).
REQ-022 char_valid_i SHALL be ignored while in CLEAR.

Reset
REQ-023 While rstn_i is low, SHALL force: state IDLE; cursor (0,0); wr_en_o 0; col_w_o, row_w_o and din_o 0; busy_o 0.
REQ-024 Reset asserted mid-clear SHALL abort the sweep immediately, leaving the screen partially cleared.

Configuration
REQ-025 Macro TEXT_WRITER_CLEAR_EN defined: SHALL include the CLEAR state and clear counter, with FF behaving as in REQ-020.
REQ-026 Macro TEXT_WRITER_CLEAR_EN undefined: CLEAR logic SHALL be absent, FF SHALL be treated as in REQ-019, and busy_o SHALL be tied to 0.

Structure
REQ-027 The shared package vga_pkg SHALL hold H_TILES, V_TILES, the address and data widths, the ASCII constants (CR, LF, BS, FF) and the state typedef.
REQ-028 The cursor column/row counter with wrap SHALL be a sub-module named text_cursor, with inc, newline, dec and home controls.

Verification
REQ-029 After reset, send 'A' (0x41): the next cycle shows wr_en_o=1, col 0, row 0, din 0x41; the cursor becomes (1,0).
REQ-030 Send 80 back-to-back printable characters from (0,0): 80 consecutive write pulses, with the last at col 79; the cursor ends at (0,1).
REQ-031 Cursor at (5,29), send LF: no write; the cursor becomes (0,0). Then send BS: no write; the cursor stays (0,0).
REQ-032 Cursor at (3,2), send BS: write of 0x00 at (2,2); the cursor becomes (2,2).
REQ-033 With the macro defined, send FF: ready is low and busy is high for 2400 cycles, with writes covering (0,0) to (79,29); then the cursor is (0,0) and ready is high. Without the macro, FF causes no write.
REQ-034 Assert rstn_i 100 cycles into a clear: outputs take their reset values within the same cycle, and ready is high after release.
